// File: rtl/fetch_ctrl_pkg.sv
// Shared types and widths for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned IDX_W   = 32;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer catching a read that returns while the consumer stalls.
module fetch_skid
  import fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [IDX_W-1:0]   index_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] data_o,
  output logic [IDX_W-1:0]   index_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] data_q;
  logic [IDX_W-1:0]   index_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      index_q <= index_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign index_o = index_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: loader writes into the ICache, then sequential fetch with
// stall handling, branch redirect and a one-entry skid buffer.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [IDX_W-1:0] RESET_INDEX = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [IDX_W-1:0]   ld_index,
  input  logic [INSTR_W-1:0] ld_instr,
  input  logic               boot_done,
  input  logic               stall,
  input  logic               branch_valid,
  input  logic [IDX_W-1:0]   branch_delta,
  output logic               ic_not_enable,
  output logic               ic_write_enable,
  output logic [IDX_W-1:0]   ic_write_index,
  output logic [INSTR_W-1:0] ic_write_instruction,
  output logic [IDX_W-1:0]   ic_index,
  input  logic [INSTR_W-1:0] ic_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [IDX_W-1:0]   instr_index
);

  fetch_state_t       state_q;
  logic [IDX_W-1:0]   pc_q;
  logic               inflight_q;
  logic [IDX_W-1:0]   inflight_idx_q;
  logic               instr_valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [IDX_W-1:0]   instr_index_q;

  logic               wr;
  logic               br_take;
  logic               hold;
  logic               issue;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_data;
  logic [IDX_W-1:0]   skid_index;

  assign wr      = ld_valid & ~rst;
  assign br_take = branch_valid & instr_valid_q;
  assign hold    = stall & instr_valid_q & ~br_take;
  // A read is never issued in a branch cycle: its target pc is not known yet.
  assign issue   = (state_q != LOAD) & ~wr & ~stall & ~skid_valid & ~br_take;

  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush_i (br_take),
    .push_i  (hold & inflight_q),
    .pop_i   (~hold & ~br_take),
    .data_i  (ic_data),
    .index_i (inflight_idx_q),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .index_o (skid_index)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LOAD;
      pc_q           <= RESET_INDEX;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      instr_valid_q  <= 1'b0;
      instr_q        <= '0;
      instr_index_q  <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) inflight_idx_q <= pc_q;

      if (br_take)    pc_q <= instr_index_q + branch_delta;
      else if (issue) pc_q <= pc_q + IDX_W'(1);

      unique case (state_q)
        LOAD:     if (boot_done && !ld_valid) state_q <= RUN;
        RUN:      if (br_take) state_q <= REDIRECT;
        REDIRECT: if (issue) state_q <= RUN;
        default:  state_q <= LOAD;
      endcase

      // Skid entry is older than any in-flight read, so it drains first.
      if (br_take) begin
        instr_valid_q <= 1'b0;
      end else if (!hold) begin
        if (skid_valid) begin
          instr_valid_q <= 1'b1;
          instr_q       <= skid_data;
          instr_index_q <= skid_index;
        end else if (inflight_q) begin
          instr_valid_q <= 1'b1;
          instr_q       <= ic_data;
          instr_index_q <= inflight_idx_q;
        end else begin
          instr_valid_q <= 1'b0;
        end
      end
    end
  end

  assign ld_ready             = wr;
  assign ic_write_enable      = wr;
  assign ic_write_index       = ld_index;
  assign ic_write_instruction = ld_instr;
  assign ic_not_enable        = ~issue;
  assign ic_index             = pc_q;
  assign instr_valid          = instr_valid_q;
  assign instr                = instr_q;
  assign instr_index          = instr_index_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 16-entry synchronous ICache model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_index;
  logic [15:0] ld_instr;
  logic        boot_done;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_delta;
  logic        ic_not_enable;
  logic        ic_write_enable;
  logic [31:0] ic_write_index;
  logic [15:0] ic_write_instruction;
  logic [31:0] ic_index;
  logic [15:0] ic_data = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [31:0] instr_index;

  logic [15:0] mem    [16];
  logic [15:0] shadow [16];
  int unsigned total = 0;
  int unsigned bad   = 0;

  fetch_ctrl #(.RESET_INDEX(32'd0)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ld_valid             (ld_valid),
    .ld_ready             (ld_ready),
    .ld_index             (ld_index),
    .ld_instr             (ld_instr),
    .boot_done            (boot_done),
    .stall                (stall),
    .branch_valid         (branch_valid),
    .branch_delta         (branch_delta),
    .ic_not_enable        (ic_not_enable),
    .ic_write_enable      (ic_write_enable),
    .ic_write_index       (ic_write_index),
    .ic_write_instruction (ic_write_instruction),
    .ic_index             (ic_index),
    .ic_data              (ic_data),
    .instr_valid          (instr_valid),
    .instr                (instr),
    .instr_index          (instr_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ic_write_enable) mem[ic_write_index[3:0]] <= ic_write_instruction;
    if (!ic_not_enable)  ic_data <= mem[ic_index[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] idx);
    chk({tag, "_valid"}, 32'(instr_valid), 32'(v));
    if (v) begin
      chk({tag, "_index"}, instr_index, idx);
      chk({tag, "_instr"}, 32'(instr), 32'(shadow[idx[3:0]]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 16'hB000 + 16'(i);
      shadow[i] = 16'hB000 + 16'(i);
    end
    rst = 1'b1; ld_valid = 1'b0; ld_index = '0; ld_instr = '0;
    boot_done = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_delta = '0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_index", instr_index, 32'd0);
    chk("rst_ne", 32'(ic_not_enable), 32'd1);
    chk("rst_we", 32'(ic_write_enable), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_ic_index", ic_index, 32'd0);

    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_index = 32'(i); ld_instr = 16'hA001 + 16'(i); boot_done = 1'b1;
      shadow[i] = 16'hA001 + 16'(i);
      look();
      chk("ld_ready", 32'(ld_ready), 32'd1);
      chk("ld_we", 32'(ic_write_enable), 32'd1);
      chk("ld_wr_index", ic_write_index, 32'(i));
      chk("ld_ne", 32'(ic_not_enable), 32'd1);
      tick();
    end
    ld_valid = 1'b0;
    look(); chk("boot_wait_ne", 32'(ic_not_enable), 32'd1);
    tick(); look();
    chk("r0_ne", 32'(ic_not_enable), 32'd0);
    chk("r0_ic_index", ic_index, 32'd0);
    tick(); look(); chk_out("r1", 1'b0, 32'd0);
    tick(); look(); chk_out("r2", 1'b1, 32'd0);

    tick(); stall = 1'b1; look();
    chk_out("r3", 1'b1, 32'd1);
    chk("stall_ne", 32'(ic_not_enable), 32'd1);
    tick(); look(); chk_out("r4_hold", 1'b1, 32'd1);
    tick(); look(); chk_out("r5_hold", 1'b1, 32'd1);
    tick(); stall = 1'b0; look();
    chk_out("r6_hold", 1'b1, 32'd1);
    chk("skid_drain_ne", 32'(ic_not_enable), 32'd1);
    tick(); look();
    chk_out("r7", 1'b1, 32'd2);
    chk("r7_ic_index", ic_index, 32'd3);
    tick(); look(); chk_out("r8", 1'b0, 32'd0);

    tick(); branch_valid = 1'b1; branch_delta = 32'hFFFF_FFFE; look();
    chk_out("r9", 1'b1, 32'd3);
    chk("br_ne", 32'(ic_not_enable), 32'd1);
    tick(); branch_valid = 1'b0; look();
    chk_out("r10_bubble", 1'b0, 32'd0);
    chk("redir_ic_index", ic_index, 32'd1);
    chk("redir_ne", 32'(ic_not_enable), 32'd0);
    tick(); look(); chk_out("r11", 1'b0, 32'd0);
    tick(); look(); chk_out("r12", 1'b1, 32'd1);
    tick(); look(); chk_out("r13", 1'b1, 32'd2);
    tick(); look(); chk_out("r14", 1'b1, 32'd3);
    tick(); look(); chk_out("r15", 1'b1, 32'd4);

    tick(); ld_valid = 1'b1; ld_index = 32'd7; ld_instr = 16'hC007; look();
    shadow[7] = 16'hC007;
    chk("run_wr_en", 32'(ic_write_enable), 32'd1);
    chk("run_wr_ne", 32'(ic_not_enable), 32'd1);
    chk("run_wr_pc", ic_index, 32'd7);
    chk_out("r16", 1'b1, 32'd5);
    tick(); ld_valid = 1'b0; look();
    chk("resume_ic_index", ic_index, 32'd7);
    chk("resume_ne", 32'(ic_not_enable), 32'd0);
    chk_out("r17", 1'b1, 32'd6);
    tick(); look(); chk_out("r18", 1'b0, 32'd0);

    tick(); branch_valid = 1'b1; branch_delta = 32'hFFFF_FFF8; look();
    chk_out("r19", 1'b1, 32'd7);
    tick(); branch_valid = 1'b0; look();
    chk("wrap_issue", ic_index, 32'hFFFF_FFFF);
    chk_out("r20", 1'b0, 32'd0);
    tick(); branch_valid = 1'b1; branch_delta = 32'd5; look();
    chk("wrap_pc0", ic_index, 32'd0);
    chk_out("r21", 1'b0, 32'd0);
    tick(); branch_valid = 1'b0; look(); chk_out("r22", 1'b1, 32'hFFFF_FFFF);

    tick(); stall = 1'b1; branch_valid = 1'b1; branch_delta = 32'd2; look();
    chk_out("r23", 1'b1, 32'd0);
    tick(); stall = 1'b0; branch_valid = 1'b0; look();
    chk_out("r24", 1'b0, 32'd0);
    chk("br_stall_ic_index", ic_index, 32'd2);
    tick(); look(); chk_out("r25", 1'b0, 32'd0);
    tick(); look(); chk_out("r26", 1'b1, 32'd2);
    stall = 1'b1;
    tick(); look(); chk_out("r27_hold", 1'b1, 32'd2);

    rst = 1'b1; ld_valid = 1'b1; ld_index = 32'd9; ld_instr = 16'hDEAD;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", 32'(instr), 32'd0);
    chk("arst_index", instr_index, 32'd0);
    chk("arst_ne", 32'(ic_not_enable), 32'd1);
    chk("arst_we", 32'(ic_write_enable), 32'd0);
    chk("arst_ready", 32'(ld_ready), 32'd0);
    chk("arst_ic_index", ic_index, 32'd0);
    tick();
    tick(); rst = 1'b0; ld_valid = 1'b0; stall = 1'b0; boot_done = 1'b0; look();
    chk("post_rst_ne", 32'(ic_not_enable), 32'd1);
    chk_out("post_rst", 1'b0, 32'd0);
    tick(); look();
    chk("still_load_ne", 32'(ic_not_enable), 32'd1);
    boot_done = 1'b1;
    tick(); look();
    chk("boot2_ic_index", ic_index, 32'd0);
    chk("boot2_ne", 32'(ic_not_enable), 32'd0);
    tick(); look(); chk_out("b1", 1'b0, 32'd0);
    tick(); look(); chk_out("b2", 1'b1, 32'd0);
    tick(); look(); chk_out("b3", 1'b1, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
